// File: rtl/pwm_from_count.sv
// pwm_from_count
// Turns the count of a free-running up counter into a registered PWM output.
// Duty values arrive through a valid/ready port into a shadow register. They
// are promoted to the active duty only at a counter wrap, or when the block
// resynchronises to the counter. Count discontinuities raise a sticky error
// and force a resync.

module pwm_from_count #(
  parameter int CW = 4,
  parameter int DW = CW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic [DW-1:0] duty_in,
  input  logic          duty_valid,
  output logic          duty_ready,
  input  logic          err_clr,
  output logic          pwm,
  output logic          wrap,
  output logic [DW-1:0] active_duty,
  output logic          sync_err
);

  // 2^CW: the largest legal duty, which means always high.
  localparam logic [DW-1:0] DUTY_MAX = {1'b1, {CW{1'b0}}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_WAIT_SYNC = 1'b0,
    ST_RUN       = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_pwm;
  logic          r_wrap;
  logic [DW-1:0] r_active;
  logic [DW-1:0] r_shadow;
  logic          r_pending;
  logic          r_sync_err;
  logic [CW-1:0] r_prev_cnt;

  state_t        w_state_nxt;
  logic          w_pwm_nxt;
  logic          w_wrap_nxt;
  logic [DW-1:0] w_active_nxt;
  logic [DW-1:0] w_shadow_nxt;
  logic          w_pending_nxt;
  logic          w_err_set;
  logic          w_err_nxt;
  logic [CW-1:0] w_prev_nxt;

  logic          w_xfer;
  logic [DW-1:0] w_duty_sat;
  logic [CW-1:0] w_cnt_expect;
  logic          w_is_wrap;

  // A new duty may enter the shadow register only while nothing is pending.
  assign w_xfer       = duty_valid & ~r_pending;
  // Out-of-range requests are clamped to the always-high duty.
  assign w_duty_sat   = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
  // The next count we expect from a healthy counter (modulo 2^CW).
  assign w_cnt_expect = r_prev_cnt + CNT_ONE;
  assign w_is_wrap    = (r_prev_cnt == CNT_MAX) && (cnt == CNT_ZERO);

  // Next-state, duty promotion, PWM compare and shadow-load logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_pwm_nxt     = 1'b0;
    w_wrap_nxt    = 1'b0;
    w_active_nxt  = r_active;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_err_set     = 1'b0;
    w_prev_nxt    = r_prev_cnt;

    if (!en) begin
      // Disabled: park in resync. The output stays low and no sequence check runs.
      w_state_nxt = ST_WAIT_SYNC;
    end else begin
      case (r_state)
        ST_WAIT_SYNC: begin
          if (cnt == CNT_ZERO) begin
            // Lock on at count 0. Take the buffered duty, and drive the
            // first RUN cycle from cnt=0 against that duty.
            w_state_nxt   = ST_RUN;
            w_active_nxt  = r_shadow;
            w_pending_nxt = 1'b0;
            w_prev_nxt    = cnt;
            w_pwm_nxt     = ({1'b0, cnt} < r_shadow);
          end else begin
            w_state_nxt = ST_WAIT_SYNC;
          end
        end
        ST_RUN: begin
          if (cnt != w_cnt_expect) begin
            // Counter jumped: flag it and wait for the next count 0.
            w_state_nxt = ST_WAIT_SYNC;
            w_err_set   = 1'b1;
          end else begin
            if (w_is_wrap) begin
              w_wrap_nxt = 1'b1;
              if (r_pending) begin
                w_active_nxt  = r_shadow;
                w_pending_nxt = 1'b0;
              end else begin
                w_pending_nxt = r_pending;
              end
            end else begin
              w_wrap_nxt = 1'b0;
            end
            // The compare uses the duty that applies from this cycle on.
            w_pwm_nxt  = ({1'b0, cnt} < w_active_nxt);
            w_prev_nxt = cnt;
          end
        end
        default: begin
          w_state_nxt = ST_WAIT_SYNC;
        end
      endcase
    end

    // A transfer only happens with pending=0, so it never collides with a
    // promotion. Its pending=1 also overrides the clear done on resync entry.
    if (w_xfer) begin
      w_shadow_nxt  = w_duty_sat;
      w_pending_nxt = 1'b1;
    end else begin
      w_shadow_nxt = w_shadow_nxt;
    end
  end

  // Sticky error: a new error wins over a clear in the same cycle.
  always_comb begin
    w_err_nxt = r_sync_err;
    if (w_err_set) begin
      w_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_sync_err;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_WAIT_SYNC;
      r_pwm      <= 1'b0;
      r_wrap     <= 1'b0;
      r_active   <= {DW{1'b0}};
      r_shadow   <= {DW{1'b0}};
      r_pending  <= 1'b0;
      r_sync_err <= 1'b0;
      r_prev_cnt <= {CW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_pwm      <= w_pwm_nxt;
      r_wrap     <= w_wrap_nxt;
      r_active   <= w_active_nxt;
      r_shadow   <= w_shadow_nxt;
      r_pending  <= w_pending_nxt;
      r_sync_err <= w_err_nxt;
      r_prev_cnt <= w_prev_nxt;
    end
  end

  assign duty_ready  = ~r_pending;
  assign pwm         = r_pwm;
  assign wrap        = r_wrap;
  assign active_duty = r_active;
  assign sync_err    = r_sync_err;

endmodule

// File: doc/pwm_from_count.md
Name: pwm_from_count

Overview:
- Downstream consumer of the free-running up counter.
- Takes the counter's count value and produces a registered PWM output whose duty is set through a valid/ready load port.
- New duty values are double-buffered and take effect only at a counter wrap (max -> 0), so periods are never glitched.
- Also flags count-sequence discontinuities so a misbehaving or reset counter is detected.

Parameters:
- CW, 4, width of the incoming count; period = 2^CW clocks.
- DW, CW+1, duty width; legal duty 0..2^CW (0 = always low, 2^CW = always high).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- cnt  in  CW  count value from the upstream counter, sampled every clk.
- duty_in  in  DW  new duty value.
- duty_valid  in  1  duty_in is valid.
- duty_ready  out  1  shadow register can accept a value.
- err_clr  in  1  clears sync_err.
- pwm  out  1  PWM output, registered.
- wrap  out  1  one-cycle pulse on each detected wrap.
- active_duty  out  DW  duty currently in use.
- sync_err  out  1  sticky flag: count discontinuity seen.

Behaviour:
- Reset (rst=0, async): state=WAIT_SYNC; pwm=0, wrap=0, duty_ready=1, active_duty=0, shadow=0, pending=0, sync_err=0, prev_cnt=0.
- State WAIT_SYNC:
  - pwm=0.
  - If en=1 and cnt==0: go to RUN, active_duty<=shadow, pending<=0.
  - The first RUN-cycle pwm reflects cnt=0 against the new active_duty.
- State RUN:
  - Each cycle, pwm <= (cnt < active_duty), compared unsigned in DW bits.
  - pwm latency is 1 clk from cnt.
  - prev_cnt <= cnt.
- Wrap detect (RUN only): prev_cnt==2^CW-1 and cnt==0.
  - On wrap: wrap<=1 for one cycle.
  - If pending=1: active_duty<=shadow, pending<=0.
  - The pwm computed in that same cycle already uses the new duty.
- Sequence check (RUN only): cnt != (prev_cnt+1) mod 2^CW.
  - On a mismatch: sync_err<=1, state<=WAIT_SYNC, pwm<=0.
  - pending and shadow are retained.
- sync_err:
  - Cleared only by reset or err_clr=1.
  - If err_clr=1 and a new error occur in the same cycle, set wins.
- en=0 in any state:
  - Next state WAIT_SYNC, pwm<=0, wrap<=0.
  - shadow, pending and active_duty are retained.
  - No sequence check is performed.
- Load handshake:
  - duty_ready = !pending (combinational from the register).
  - Transfer occurs when duty_valid && duty_ready: shadow <= min(duty_in, 2^CW), pending<=1.
  - Accepted in WAIT_SYNC and RUN alike.
- Simultaneous transfer and wrap (only possible when pending=0):
  - The wrap does not load, because pending was 0.
  - The new value is applied at the next wrap, or at the next WAIT_SYNC -> RUN entry.
- Reset mid-period: all outputs return to reset values immediately, and resync is required.

Test Plan:
- Reset, load duty 5, en=1, counter free-running 0..15 -> after the first cnt=0, pwm high for exactly 5 clks and low for 11 per 16-clk period; pwm lags cnt by 1 clk; wrap pulses every 16 clks.
- In RUN with duty 5, load duty 12 at cnt=7 -> duty_ready drops the next cycle; the current period still has 5 high clks; from the next wrap active_duty=12, there are 12 high clks, and duty_ready=1 again.
- Boundary duties 0, 16, and 20 -> pwm is constantly 0; constantly 1; constantly 1 with active_duty=16 (saturated).
- Hold duty_valid with a new value while pending=1 -> no transfer and shadow unchanged; the transfer occurs in the cycle after the wrap clears pending.
- Drive cnt 3,4,9 in RUN -> sync_err=1, pwm=0, state WAIT_SYNC; resumes at the next cnt=0; sync_err stays 1 until err_clr pulse.
- Deassert en mid-period, then re-enable; separately, assert rst low mid-period -> en: pwm=0 until the next cnt=0 and active_duty is retained; rst: all outputs at reset values asynchronously and active_duty=0.
